// File: rtl/fpga_transmitter.sv
// rtl/fpga_transmitter.sv - byte serialiser with four-phase acknowledge handshake (optional timeout: FPGA_TRANSMITTER_TIMEOUT_EN)
module fpga_transmitter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       load,
    output logic       ready,
    output logic       data,
    output logic       send,
    output logic       finish,
    input  logic       acknowledge,
    output logic       error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        FINISH  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_cnt;
    logic [15:0] wait_cnt;
    logic        timeout_hit;

`ifdef FPGA_TRANSMITTER_TIMEOUT_EN
    // The wait counter is about to reach the limit at this edge, so the
    // handshake is abandoned after exactly TIMEOUT_CYCLES waiting cycles.
    assign timeout_hit = (({1'b0, wait_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES))
                         && ((state == FINISH) || (state == RELEASE));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register; reset aborts any frame in flight immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, shift eight bits, then the four-phase handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (bit_cnt == 3'd7) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (acknowledge) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (timeout_hit || !acknowledge) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode straight from flops: no input-to-output combinational path.
    always_comb begin
        ready  = (state == IDLE);
        send   = (state == SEND);
        finish = (state == FINISH);
        data   = (state == SEND) && shift_reg[7];
    end

    // Datapath: shift register, bit counter and saturating wait counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
            wait_cnt  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shift_reg <= data_in;
                        bit_cnt   <= 3'd0;
                    end
                end
                SEND: begin
                    shift_reg <= {shift_reg[6:0], 1'b0};
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        wait_cnt <= 16'h0000;
                    end
                end
                FINISH, RELEASE: begin
                    if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    shift_reg <= shift_reg;
                end
            endcase
        end
    end

`ifdef FPGA_TRANSMITTER_TIMEOUT_EN
    // Sticky timeout flag, cleared only by the next accepted load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            error <= 1'b0;
        end else if ((state == IDLE) && load) begin
            error <= 1'b0;
        end else if (timeout_hit) begin
            error <= 1'b1;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_transmitter.sv
// tb/tb_fpga_transmitter.sv - self-checking bench for fpga_transmitter
module tb_fpga_transmitter;

`ifdef FPGA_TRANSMITTER_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 255;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       load;
    logic       acknowledge = 1'b0;
    logic       ready, data, send, finish, error;

    always #5 clock = ~clock;

    fpga_transmitter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .load        (load),
        .ready       (ready),
        .data        (data),
        .send        (send),
        .finish      (finish),
        .acknowledge (acknowledge),
        .error       (error)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Acknowledge responder: 0 low, 1 immediate, 2 one-cycle delayed, 3 forced high.
    int   ack_mode = 0;
    logic fin_d = 1'b0;
    always @(posedge clock) begin
        #1;
        case (ack_mode)
            1:       acknowledge = finish;
            2:       acknowledge = fin_d;
            3:       acknowledge = 1'b1;
            default: acknowledge = 1'b0;
        endcase
        fin_d = finish;
    end

    // Reference model: a queue of bits still to appear on the line, then a
    // wait phase (1 = awaiting ack high, 2 = awaiting ack low).
    bit mq[$];
    int mph  = 0;
    int mw   = 0;
    bit merr = 1'b0;
    always @(posedge clock or posedge reset) begin
        bit tmo;
        tmo = 1'b0;
        if (reset) begin
            mq.delete();
            mph  = 0;
            mw   = 0;
            merr = 1'b0;
        end else if (mq.size() != 0) begin
            void'(mq.pop_front());
            if (mq.size() == 0) begin
                mph = 1;
                mw  = 0;
            end
        end else if (mph != 0) begin
`ifdef FPGA_TRANSMITTER_TIMEOUT_EN
            tmo = ((mw + 1) == TMO);
`endif
            if (tmo) begin
                mph  = 0;
                merr = 1'b1;
            end else if (mph == 1 && acknowledge) begin
                mph = 2;
            end else if (mph == 2 && !acknowledge) begin
                mph = 0;
            end
            if (mw < 65535) mw++;
        end else if (load) begin
            for (int i = 7; i >= 0; i--) mq.push_back(data_in[i]);
            merr = 1'b0;
        end
    end

    bit rx[$];
    int rises[$];
    int cyc = 0;
    bit send_q = 1'b0;

    task automatic take(output int n, output logic [15:0] v);
        n = rx.size();
        v = '0;
        foreach (rx[i]) v = {v[14:0], rx[i]};
        rx.delete();
    endtask

    task automatic pulse_load(input logic [7:0] b);
        @(posedge clock); #2;
        load = 1'b1;
        data_in = b;
        @(posedge clock); #2;
        load = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int bound);
        int k;
        k = 0;
        while (k < bound) begin
            @(negedge clock);
            if (ready) break;
            k++;
        end
        chk(name, (k < bound), 1);
    endtask

    initial begin
        int          n;
        int          k;
        logic [15:0] v;
        reset   = 1'b1;
        load    = 1'b0;
        data_in = 8'h00;
        fork
            forever begin
                @(negedge clock);
                cyc++;
                chk("ready", ready, (mq.size() == 0 && mph == 0));
                chk("send", send, (mq.size() != 0));
                chk("data", data, (mq.size() != 0) ? mq[0] : 1'b0);
                chk("finish", finish, (mph == 1));
                chk("error", error, merr);
                if (send) rx.push_back(data);
                if (send && !send_q) rises.push_back(cyc);
                send_q = send;
            end
        join_none

        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_send", send, 0);
        chk("rst_data", data, 0);
        chk("rst_finish", finish, 0);
        chk("rst_error", error, 0);
        @(posedge clock); #2;
        reset = 1'b0;

        // A5 with a delayed responder, first load right after reset.
        ack_mode = 2;
        pulse_load(8'hA5);
        wait_ready("a5_done", 40);
        take(n, v);
        chk("a5_nbits", n, 8);
        chk("a5_byte", v[7:0], 8'hA5);

        // Back-to-back 00 then FF with load held high.
        ack_mode = 1;
        rises.delete();
        @(posedge clock); #2;
        load = 1'b1;
        data_in = 8'h00;
        @(posedge clock); #2;
        data_in = 8'hFF;
        k = 0;
        while (rises.size() < 2 && k < 40) begin
            @(negedge clock);
            k++;
        end
        load = 1'b0;
        chk("b2b_second_start", (rises.size() >= 2), 1);
        wait_ready("b2b_done", 40);
        take(n, v);
        chk("b2b_nbits", n, 16);
        chk("b2b_bits", v, 16'h00FF);
        if (rises.size() >= 2) chk("b2b_spacing", rises[1] - rises[0], 11);

        // Load during SEND must be ignored.
        pulse_load(8'hC3);
        repeat (2) @(posedge clock);
        #2;
        load = 1'b1;
        data_in = 8'h3C;
        @(posedge clock); #2;
        load = 1'b0;
        wait_ready("c3_done", 40);
        repeat (6) @(negedge clock);
        take(n, v);
        chk("c3_nbits", n, 8);
        chk("c3_byte", v[7:0], 8'hC3);

        // Reset on the 4th send cycle of 81, then a clean 7E.
        pulse_load(8'h81);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_send", send, 0);
        chk("abort_data", data, 0);
        chk("abort_finish", finish, 0);
        chk("abort_ready", ready, 1);
        take(n, v);
        chk("abort_nbits", n, 3);
        chk("abort_bits", v[2:0], 3'b100);
        @(posedge clock); #2;
        reset = 1'b0;
        pulse_load(8'h7E);
        wait_ready("7e_done", 40);
        take(n, v);
        chk("7e_nbits", n, 8);
        chk("7e_byte", v[7:0], 8'h7E);

`ifdef FPGA_TRANSMITTER_TIMEOUT_EN
        // No acknowledge: finish for TMO cycles, then error and idle.
        ack_mode = 0;
        pulse_load(8'h5A);
        k = 0;
        while (!finish && k < 50) begin
            @(negedge clock);
            k++;
        end
        n = 0;
        while (finish && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("tmo_finish_cycles", n, 10);
        chk("tmo_error", error, 1);
        chk("tmo_ready", ready, 1);
        take(n, v);
        chk("tmo_byte", v[7:0], 8'h5A);
        ack_mode = 1;
        pulse_load(8'h33);
        @(negedge clock);
        chk("tmo_error_clear", error, 0);
        wait_ready("tmo_next_done", 40);
        take(n, v);
        chk("tmo_next_byte", v[7:0], 8'h33);
`else
        // Acknowledge withheld for 1000 cycles: wait indefinitely.
        ack_mode = 0;
        pulse_load(8'h96);
        k = 0;
        while (!finish && k < 50) begin
            @(negedge clock);
            k++;
        end
        repeat (1000) @(negedge clock);
        chk("hold_finish", finish, 1);
        chk("hold_error", error, 0);
        ack_mode = 3;
        k = 0;
        while (finish && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("hold_ack_seen", (k < 20), 1);
        ack_mode = 0;
        wait_ready("hold_done", 20);
        take(n, v);
        chk("hold_nbits", n, 8);
        chk("hold_byte", v[7:0], 8'h96);
`endif

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
